host_mailbox: RTL and testbench
===============================

// Module: host_mailbox
// PURPOSE
//  Data-bus responder for the core's tohost/fromhost protocol; the target end of the writes the core issues.
//  Decodes TOHOST/FROMHOST/STATUS words on the core data port, queues tohost writes in a FIFO and drains
//  them to a host-side valid/ready stream. Holds a fromhost word the host deposits for the core to poll.
//  Sits beside dual_port_mem on dm_*; top muxes dm_dout with data_out_o using hit_o, and ORs busy_o into dm_busy.
// PARAMETERS
//  TOHOST_ADDR    32'h80001000  word address of tohost (write pushes FIFO; read returns 0)
//  FROMHOST_ADDR  32'h80001040  word address of fromhost (read returns value; core write clears or overwrites)
//  STATUS_ADDR    32'h80001080  read-only status word
//  FIFO_DEPTH     4             tohost FIFO entries; power of 2, >=2
// PORTS
//  clk_i            in   1   clock
//  rst_n_i          in   1   asynchronous active-low reset
//  wen_i            in   1   core data write enable
//  addr_i           in   32  core data address (exact word match; no byte lanes)
//  data_in_i        in   32  core write data
//  data_out_o       out  32  registered read data for a hit
//  hit_o            out  1   registered: data_out_o valid for previous-cycle address
//  busy_o           out  1   stall: tohost write presented while FIFO full
//  tohost_valid_o   out  1   FIFO head valid
//  tohost_data_o    out  32  FIFO head data (0 when empty)
//  tohost_ready_i   in   1   host pops head when valid&ready
//  tohost_int_o     out  1   one-cycle pulse per accepted tohost write
//  fromhost_valid_i in   1   host deposits fromhost word
//  fromhost_data_i  in   32  host fromhost data
//  fromhost_ready_o out  1   fromhost slot empty (host may write)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, fromhost=0, accept counter=0; reset mid-operation discards FIFO contents.
//  Push: wen_i && addr_i==TOHOST_ADDR && !full -> enqueue data_in_i; tohost_int_o=1 next cycle; accept_cnt+1.
//  Full: busy_o = wen_i && addr_i==TOHOST_ADDR && full (combinational); no push, core holds request.
//   No bypass: pop in same cycle as full does not release busy until next cycle.
//  Pop: tohost_valid_o && tohost_ready_i -> dequeue; push+pop same cycle (not full) keeps count unchanged.
//  Count width $clog2(FIFO_DEPTH)+1; rd/wr pointers wrap modulo FIFO_DEPTH.
//  fromhost: host write accepted only when fromhost_ready_o=1; sets fromhost_q=data, full=(data!=0).
//   Core write to FROMHOST_ADDR sets fromhost_q=data_in_i, full=(data_in_i!=0).
//   Same-cycle host write and core write: host wins, core write dropped.
//  Read: !wen_i && addr matches any of 3 addresses -> next cycle hit_o=1, data_out_o=value; else both 0.
//  STATUS = {accept_cnt[15:0], 8'(count), 6'b0, fifo_full, fromhost_full}; writes to STATUS ignored.
//  Read of FROMHOST captures value at request cycle (pre-update if written same cycle).
// STRUCTURE
//  host_if_pkg: default address constants, STATUS bit-field localparams (ACC_MSB/LSB, CNT_MSB/LSB, FULL_BIT, FH_BIT).
//  Sub-module sync_fifo #(WIDTH,DEPTH): push/pop/full/empty/count/head; instantiated once for tohost queue.
//  host_mailbox holds decode, fromhost register, status, read register, int pulse.
// TESTING
//  1 Reset with FIFO holding 2 entries -> valid=0, data=0, STATUS reads 0, int=0.
//  2 Write 32'h1 to TOHOST, ready=1 -> int pulse 1 cycle, valid next cycle with data 32'h1, popped; accept_cnt=1.
//  3 ready=0, 5 writes 32'hA..E -> first 4 accepted, 5th holds busy_o=1; one pop -> busy drops next cycle, 32'hE queued.
//  4 FIFO at count 2, push and pop same cycle -> count stays 2, order preserved.
//  5 Host writes 32'h5 to fromhost -> ready_o=0, core read returns 32'h5, hit_o=1; core writes 0 -> ready_o=1.
//  6 Read STATUS after 3 accepts with 1 pending and fromhost full -> 32'h0003_0101.

Source files
------------

// File: rtl/host_if_pkg.sv
// Shared constants for the host mailbox: default decode addresses, STATUS
// word field positions and the STATUS packing helper.
package host_if_pkg;

    localparam logic [31:0] DEF_TOHOST_ADDR   = 32'h8000_1000;
    localparam logic [31:0] DEF_FROMHOST_ADDR = 32'h8000_1040;
    localparam logic [31:0] DEF_STATUS_ADDR   = 32'h8000_1080;
    localparam int          DEF_FIFO_DEPTH    = 4;

    localparam int ACC_MSB  = 31;
    localparam int ACC_LSB  = 16;
    localparam int CNT_MSB  = 15;
    localparam int CNT_LSB  = 8;
    localparam int FULL_BIT = 1;
    localparam int FH_BIT   = 0;

    function automatic logic [31:0] pack_status(input logic [15:0] acc,
                                                input logic [7:0]  cnt,
                                                input logic        fifo_full,
                                                input logic        fh_full);
        logic [31:0] s;
        s                  = 32'h0000_0000;
        s[ACC_MSB:ACC_LSB] = acc;
        s[CNT_MSB:CNT_LSB] = cnt;
        s[FULL_BIT]        = fifo_full;
        s[FH_BIT]          = fh_full;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state: guarded push/pop, pointers wrap naturally at power-of-2 depth.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/host_mailbox.sv
// Core data-bus responder for tohost/fromhost: queues tohost writes toward the
// host, holds a host-deposited fromhost word, and serves STATUS reads.
module host_mailbox
    import host_if_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR   = DEF_TOHOST_ADDR,
    parameter logic [31:0] FROMHOST_ADDR = DEF_FROMHOST_ADDR,
    parameter logic [31:0] STATUS_ADDR   = DEF_STATUS_ADDR,
    parameter int          FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wen_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_in_i,
    output logic [31:0] data_out_o,
    output logic        hit_o,
    output logic        busy_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o,
    input  logic        tohost_ready_i,
    output logic        tohost_int_o,
    input  logic        fromhost_valid_i,
    input  logic [31:0] fromhost_data_i,
    output logic        fromhost_ready_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          to_sel_s, fh_sel_s, st_sel_s;
    logic          push_s, pop_s, host_acc_s, core_fh_wr_s, rd_hit_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [CW-1:0] fifo_count_s;
    logic [31:0]   fifo_head_s, status_s, rd_data_s;

    logic [31:0]   fh_q, fh_d, data_out_q, data_out_d;
    logic          fh_full_q, fh_full_d, hit_q, hit_d, int_q, int_d;
    logic [15:0]   acc_q, acc_d;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tohost_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .data_i  (data_in_i),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s),
        .head_o  (fifo_head_s)
    );

    // Full is a registered flag, so a same-cycle pop cannot release the stall.
    assign busy_o           = wen_i && to_sel_s && fifo_full_s;
    assign tohost_valid_o   = !fifo_empty_s;
    assign tohost_data_o    = fifo_head_s;
    assign fromhost_ready_o = !fh_full_q;
    assign data_out_o       = data_out_q;
    assign hit_o            = hit_q;
    assign tohost_int_o     = int_q;

    // Address decode, fromhost arbitration (host wins) and read-data mux.
    always_comb begin
        to_sel_s     = (addr_i == TOHOST_ADDR);
        fh_sel_s     = (addr_i == FROMHOST_ADDR);
        st_sel_s     = (addr_i == STATUS_ADDR);
        push_s       = wen_i && to_sel_s && !fifo_full_s;
        pop_s        = tohost_ready_i && !fifo_empty_s;
        host_acc_s   = fromhost_valid_i && !fh_full_q;
        core_fh_wr_s = wen_i && fh_sel_s && !host_acc_s;
        status_s     = pack_status(acc_q, 8'(fifo_count_s), fifo_full_s, fh_full_q);
        rd_hit_s     = !wen_i && (to_sel_s || fh_sel_s || st_sel_s);

        fh_d      = fh_q;
        fh_full_d = fh_full_q;
        if (host_acc_s) begin
            fh_d      = fromhost_data_i;
            fh_full_d = (fromhost_data_i != 32'h0000_0000);
        end else if (core_fh_wr_s) begin
            fh_d      = data_in_i;
            fh_full_d = (data_in_i != 32'h0000_0000);
        end else begin
            fh_d      = fh_q;
            fh_full_d = fh_full_q;
        end

        rd_data_s = 32'h0000_0000;
        if (fh_sel_s) begin
            rd_data_s = fh_q;
        end else if (st_sel_s) begin
            rd_data_s = status_s;
        end else begin
            rd_data_s = 32'h0000_0000;
        end

        hit_d      = rd_hit_s;
        data_out_d = rd_hit_s ? rd_data_s : 32'h0000_0000;
        int_d      = push_s;
        acc_d      = push_s ? (acc_q + 16'd1) : acc_q;
    end

    // Mailbox state and registered bus outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fh_q       <= 32'h0000_0000;
            fh_full_q  <= 1'b0;
            data_out_q <= 32'h0000_0000;
            hit_q      <= 1'b0;
            int_q      <= 1'b0;
            acc_q      <= 16'h0000;
        end else begin
            fh_q       <= fh_d;
            fh_full_q  <= fh_full_d;
            data_out_q <= data_out_d;
            hit_q      <= hit_d;
            int_q      <= int_d;
            acc_q      <= acc_d;
        end
    end

endmodule

// File: tb/tb_host_mailbox.sv
// Directed vector table plus hand-written sequences for the host mailbox.
module tb_host_mailbox;
    localparam logic [31:0] TO = 32'h8000_1000;
    localparam logic [31:0] FH = 32'h8000_1040;
    localparam logic [31:0] ST = 32'h8000_1080;
    localparam logic [31:0] Z  = 32'h0000_0000;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic        wen_i = 1'b0, tohost_ready_i = 1'b0, fromhost_valid_i = 1'b0;
    logic [31:0] addr_i = 32'h0, data_in_i = 32'h0, fromhost_data_i = 32'h0;
    logic [31:0] data_out_o, tohost_data_o;
    logic        hit_o, busy_o, tohost_valid_o, tohost_int_o, fromhost_ready_o;

    int checks = 0;
    int errors = 0;

    host_mailbox dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .wen_i(wen_i), .addr_i(addr_i),
        .data_in_i(data_in_i), .data_out_o(data_out_o), .hit_o(hit_o),
        .busy_o(busy_o), .tohost_valid_o(tohost_valid_o),
        .tohost_data_o(tohost_data_o), .tohost_ready_i(tohost_ready_i),
        .tohost_int_o(tohost_int_o), .fromhost_valid_i(fromhost_valid_i),
        .fromhost_data_i(fromhost_data_i), .fromhost_ready_o(fromhost_ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        logic        fhv;
        logic [31:0] fhd;
        logic        e_busy;
        logic        e_hit;
        logic [31:0] e_dout;
        logic        e_int;
        logic        e_valid;
        logic [31:0] e_tdata;
        logic        e_fhr;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic r);
        wen_i = w; addr_i = a; data_in_i = d; tohost_ready_i = r;
        fromhost_valid_i = 1'b0; fromhost_data_i = Z;
    endtask

    initial begin
        // wen addr wdata ready fhv fhd | busy hit dout int valid tdata fhready
        vecs[0]  = '{1'b0, ST, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[1]  = '{1'b1, TO, 32'h1, 1'b1, 1'b0, Z,         1'b0, 1'b0, Z, 1'b1, 1'b1, 32'h1, 1'b1};
        vecs[2]  = '{1'b0, Z, Z, 1'b1, 1'b0, Z,              1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[3]  = '{1'b0, ST, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, Z, 1'b1};
        vecs[4]  = '{1'b0, Z, Z, 1'b0, 1'b1, 32'h5,          1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[5]  = '{1'b0, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h5, 1'b0, 1'b0, Z, 1'b0};
        vecs[6]  = '{1'b0, FH, Z, 1'b0, 1'b1, 32'h7,         1'b0, 1'b1, 32'h5, 1'b0, 1'b0, Z, 1'b0};
        vecs[7]  = '{1'b0, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h5, 1'b0, 1'b0, Z, 1'b0};
        vecs[8]  = '{1'b1, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[9]  = '{1'b0, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[10] = '{1'b1, FH, 32'h9, 1'b0, 1'b0, Z,         1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[11] = '{1'b1, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[12] = '{1'b1, FH, 32'h33, 1'b0, 1'b1, 32'h22,   1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[13] = '{1'b0, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h22, 1'b0, 1'b0, Z, 1'b0};
        vecs[14] = '{1'b1, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b1};
        vecs[15] = '{1'b0, FH, Z, 1'b0, 1'b1, 32'h44,        1'b0, 1'b1, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[16] = '{1'b0, FH, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h44, 1'b0, 1'b0, Z, 1'b0};
        vecs[17] = '{1'b1, TO, 32'hA1, 1'b0, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 1'b1, 32'hA1, 1'b0};
        vecs[18] = '{1'b1, TO, 32'hA2, 1'b1, 1'b0, Z,        1'b0, 1'b0, Z, 1'b1, 1'b1, 32'hA2, 1'b0};
        vecs[19] = '{1'b0, ST, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h0003_0101, 1'b0, 1'b1, 32'hA2, 1'b0};
        vecs[20] = '{1'b0, TO, Z, 1'b1, 1'b0, Z,             1'b0, 1'b1, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[21] = '{1'b1, ST, 32'hFFFF_FFFF, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0};
        vecs[22] = '{1'b0, ST, Z, 1'b0, 1'b0, Z,             1'b0, 1'b1, 32'h0003_0001, 1'b0, 1'b0, Z, 1'b0};
        vecs[23] = '{1'b0, 32'h8000_1004, Z, 1'b0, 1'b0, Z,  1'b0, 1'b0, Z, 1'b0, 1'b0, Z, 1'b0};

        // Initial reset.
        tick();
        tick();
        chk("rst_valid", {31'h0, tohost_valid_o}, 32'h0);
        chk("rst_dout", data_out_o, Z);
        rst_n_i = 1'b1;

        // Table: drive, check combinational busy mid-cycle, then registered outputs.
        for (int i = 0; i < 24; i++) begin
            wen_i = vecs[i].wen; addr_i = vecs[i].addr; data_in_i = vecs[i].wdata;
            tohost_ready_i = vecs[i].ready;
            fromhost_valid_i = vecs[i].fhv; fromhost_data_i = vecs[i].fhd;
            #1;
            chk($sformatf("v%0d_busy", i), {31'h0, busy_o}, {31'h0, vecs[i].e_busy});
            tick();
            chk($sformatf("v%0d_hit", i), {31'h0, hit_o}, {31'h0, vecs[i].e_hit});
            chk($sformatf("v%0d_dout", i), data_out_o, vecs[i].e_dout);
            chk($sformatf("v%0d_int", i), {31'h0, tohost_int_o}, {31'h0, vecs[i].e_int});
            chk($sformatf("v%0d_valid", i), {31'h0, tohost_valid_o}, {31'h0, vecs[i].e_valid});
            chk($sformatf("v%0d_tdata", i), tohost_data_o, vecs[i].e_tdata);
            chk($sformatf("v%0d_fhready", i), {31'h0, fromhost_ready_o}, {31'h0, vecs[i].e_fhr});
        end

        // Fill to full with ready low; the fifth write stalls until a pop frees a slot.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, TO, 32'hA + 32'(k), 1'b0);
            #1;
            chk($sformatf("fill%0d_busy", k), {31'h0, busy_o}, 32'h0);
            tick();
        end
        drive(1'b1, TO, 32'hE, 1'b0);
        #1;
        chk("full_busy", {31'h0, busy_o}, 32'h1);
        tick();
        chk("full_hold_int", {31'h0, tohost_int_o}, 32'h0);
        chk("full_head", tohost_data_o, 32'hA);
        chk("full_hold_busy", {31'h0, busy_o}, 32'h1);
        tohost_ready_i = 1'b1;
        #1;
        chk("nobypass_busy", {31'h0, busy_o}, 32'h1);
        tick();
        tohost_ready_i = 1'b0;
        #1;
        chk("released_busy", {31'h0, busy_o}, 32'h0);
        chk("after_pop_head", tohost_data_o, 32'hB);
        chk("e_not_yet_int", {31'h0, tohost_int_o}, 32'h0);
        tick();
        chk("e_accept_int", {31'h0, tohost_int_o}, 32'h1);
        drive(1'b0, Z, Z, 1'b1);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d_data", k), tohost_data_o, 32'hB + 32'(k));
            tick();
        end
        chk("drained_valid", {31'h0, tohost_valid_o}, 32'h0);

        // Simultaneous push and pop at count 2 keeps count and order.
        drive(1'b1, TO, 32'h11, 1'b0);
        tick();
        drive(1'b1, TO, 32'h22, 1'b0);
        tick();
        drive(1'b1, TO, 32'h33, 1'b1);
        #1;
        chk("pp_head_before", tohost_data_o, 32'h11);
        tick();
        drive(1'b0, ST, Z, 1'b0);
        tick();
        chk("pp_status", data_out_o, 32'h000B_0201);
        chk("pp_head_after", tohost_data_o, 32'h22);
        drive(1'b0, Z, Z, 1'b1);
        tick();
        chk("pp_second", tohost_data_o, 32'h33);
        tick();
        chk("pp_empty", {31'h0, tohost_valid_o}, 32'h0);

        // Asynchronous reset with two entries queued discards them.
        drive(1'b1, TO, 32'h55, 1'b0);
        tick();
        drive(1'b1, TO, 32'h66, 1'b0);
        tick();
        drive(1'b0, Z, Z, 1'b0);
        rst_n_i = 1'b0;
        #1;
        chk("arst_valid", {31'h0, tohost_valid_o}, 32'h0);
        chk("arst_tdata", tohost_data_o, Z);
        chk("arst_int", {31'h0, tohost_int_o}, 32'h0);
        chk("arst_hit", {31'h0, hit_o}, 32'h0);
        tick();
        tick();
        rst_n_i = 1'b1;
        drive(1'b0, ST, Z, 1'b0);
        tick();
        chk("arst_status_hit", {31'h0, hit_o}, 32'h1);
        chk("arst_status", data_out_o, Z);
        drive(1'b0, FH, Z, 1'b0);
        tick();
        chk("arst_fromhost", data_out_o, Z);
        chk("arst_valid_after", {31'h0, tohost_valid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
